// File: rtl/xbar_pkg.sv
// Shared types and control-word layout helpers for the buffered stream crossbar.
// The control word packs one {en, sel} field per output, output 0 in the LSBs.
package xbar_pkg;

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } xbar_state_e;

    // A single-input crossbar still carries a 1-bit select field.
    function automatic int calc_sel_w(input int n_inputs);
        return (n_inputs > 1) ? $clog2(n_inputs) : 1;
    endfunction

    function automatic int field_lsb(input int j, input int sel_w);
        return j * (sel_w + 1);
    endfunction

    function automatic int en_bit(input int j, input int sel_w);
        return j * (sel_w + 1) + sel_w;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Registered output FIFO for one crossbar output.
// No pop-through: a push is accepted only while count < FIFO_DEPTH.
module stream_fifo #(
    parameter int BIT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [BIT_WIDTH-1:0]          push_data,
    input  logic                          pop,
    output logic [BIT_WIDTH-1:0]          pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [AW:0]          cnt;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/stream_xbar_buffered.sv
// N-input x M-output val/rdy crossbar with per-output FIFOs, multicast routing,
// and a drain-before-reconfigure handshake on the control port.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   ACTIVE | routing with cfg; control_val requests a reconfiguration
//   DRAIN  | inputs stalled, FIFOs emptying; load control once all empty
module stream_xbar_buffered
    import xbar_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int N_INPUTS   = 2,
    parameter int N_OUTPUTS  = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int SEL_W      = calc_sel_w(N_INPUTS),
    parameter int CFG_W      = N_OUTPUTS * (SEL_W + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_INPUTS*BIT_WIDTH-1:0]   recv_msg,
    input  logic [N_INPUTS-1:0]             recv_val,
    output logic [N_INPUTS-1:0]             recv_rdy,
    output logic [N_OUTPUTS*BIT_WIDTH-1:0]  send_msg,
    output logic [N_OUTPUTS-1:0]            send_val,
    input  logic [N_OUTPUTS-1:0]            send_rdy,
    input  logic [CFG_W-1:0]                control,
    input  logic                            control_val,
    output logic                            control_rdy,
    output logic [CFG_W-1:0]                cfg_o,
    output logic                            draining_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    xbar_state_e            state;
    logic [CFG_W-1:0]       cfg;
    logic [CFG_W-1:0]       cfg_rst;
    logic [SEL_W-1:0]       sel [N_OUTPUTS];
    logic [N_OUTPUTS-1:0]   route_en;
    logic [N_OUTPUTS-1:0]   fifo_full;
    logic [N_OUTPUTS-1:0]   fifo_empty;
    logic [N_OUTPUTS-1:0]   push;
    logic [N_OUTPUTS-1:0]   pop;
    logic [BIT_WIDTH-1:0]   push_data [N_OUTPUTS];
    logic [CNT_W-1:0]       fifo_count [N_OUTPUTS];
    logic [N_INPUTS-1:0]    any_dest;
    logic [N_INPUTS-1:0]    blocked;
    logic [N_INPUTS-1:0]    fire;
    logic                   all_empty;

    always_comb begin
        cfg_rst = '0;
        for (int j = 0; j < N_OUTPUTS; j++) begin
            cfg_rst[en_bit(j, SEL_W)]               = 1'b1;
            cfg_rst[field_lsb(j, SEL_W) +: SEL_W]   = SEL_W'(j % N_INPUTS);
        end
    end

    // Out-of-range selects behave exactly like a cleared enable.
    always_comb begin
        for (int j = 0; j < N_OUTPUTS; j++) begin
            sel[j]      = cfg[field_lsb(j, SEL_W) +: SEL_W];
            route_en[j] = cfg[en_bit(j, SEL_W)] && (int'(sel[j]) < N_INPUTS);
        end
    end

    always_comb begin
        any_dest = '0;
        blocked  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            for (int j = 0; j < N_OUTPUTS; j++) begin
                if (route_en[j] && (int'(sel[j]) == i)) begin
                    any_dest[i] = 1'b1;
                    if (fifo_full[j]) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign recv_rdy = (state == ACTIVE) ? (any_dest & ~blocked) : '0;
    assign fire     = recv_val & recv_rdy;

    // Every destination of an input sees the same fire bit, so multicast is atomic.
    always_comb begin
        for (int j = 0; j < N_OUTPUTS; j++) begin
            push[j]      = 1'b0;
            push_data[j] = '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                if (route_en[j] && (int'(sel[j]) == i)) begin
                    push[j]      = fire[i];
                    push_data[j] = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    always_comb begin
        all_empty = 1'b1;
        for (int j = 0; j < N_OUTPUTS; j++) begin
            if (fifo_count[j] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    assign send_val    = ~fifo_empty;
    assign pop         = ~fifo_empty & send_rdy;
    assign control_rdy = (state == DRAIN) && all_empty;
    assign cfg_o       = cfg;

    for (genvar j = 0; j < N_OUTPUTS; j++) begin : g_out
        stream_fifo #(
            .BIT_WIDTH  (BIT_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[j]),
            .push_data (push_data[j]),
            .pop       (pop[j]),
            .pop_data  (send_msg[j*BIT_WIDTH +: BIT_WIDTH]),
            .full      (fifo_full[j]),
            .empty     (fifo_empty[j]),
            .count     (fifo_count[j])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACTIVE;
            cfg        <= cfg_rst;
            draining_o <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (control_val) begin
                        state      <= DRAIN;
                        draining_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!control_val) begin
                        state      <= ACTIVE;
                        draining_o <= 1'b0;
                    end else if (all_empty) begin
                        cfg        <= control;
                        state      <= ACTIVE;
                        draining_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_xbar_buffered.sv
// Directed bench for stream_xbar_buffered at 2x2, 32-bit, depth-2 FIFOs.
// Control word: out0 in bits [1:0], out1 in [3:2], each {en, sel}.
module tb_stream_xbar_buffered;

    localparam int BW = 32;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int CW = 4;

    localparam logic [CW-1:0] CFG_DEF  = 4'hE;
    localparam logic [CW-1:0] CFG_MC0  = 4'hA;
    localparam logic [CW-1:0] CFG_SWAP = 4'hB;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI*BW-1:0]  recv_msg;
    logic [NI-1:0]     recv_val;
    logic [NI-1:0]     recv_rdy;
    logic [NO*BW-1:0]  send_msg;
    logic [NO-1:0]     send_val;
    logic [NO-1:0]     send_rdy;
    logic [CW-1:0]     control;
    logic              control_val;
    logic              control_rdy;
    logic [CW-1:0]     cfg_o;
    logic              draining_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_xbar_buffered #(
        .BIT_WIDTH  (BW),
        .N_INPUTS   (NI),
        .N_OUTPUTS  (NO),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .recv_msg    (recv_msg),
        .recv_val    (recv_val),
        .recv_rdy    (recv_rdy),
        .send_msg    (send_msg),
        .send_val    (send_val),
        .send_rdy    (send_rdy),
        .control     (control),
        .control_val (control_val),
        .control_rdy (control_rdy),
        .cfg_o       (cfg_o),
        .draining_o  (draining_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        int          idx;
        logic        accepted;

        reset       = 1'b1;
        recv_msg    = '0;
        recv_val    = '0;
        send_rdy    = '0;
        control     = '0;
        control_val = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check_val("rst_send_val",    send_val,    2'b00);
        check_val("rst_send_msg",    send_msg,    64'h0);
        check_val("rst_control_rdy", control_rdy, 1'b0);
        check_val("rst_draining",    draining_o,  1'b0);
        check_val("rst_cfg",         cfg_o,       CFG_DEF);
        check_val("rst_recv_rdy",    recv_rdy,    2'b11);

        // Default routing and one-cycle latency
        send_rdy = 2'b11;
        recv_val = 2'b11;
        recv_msg = {32'h0000_005A, 32'h0000_00A5};
        check_val("def_rdy", recv_rdy, 2'b11);
        tick();
        recv_val = 2'b00;
        check_val("def_val",  send_val,        2'b11);
        check_val("def_out0", send_msg[31:0],  32'hA5);
        check_val("def_out1", send_msg[63:32], 32'h5A);
        tick();
        check_val("def_drained", send_val, 2'b00);

        // Backpressure fills output 0
        send_rdy = 2'b00;
        recv_val = 2'b01;
        recv_msg = {32'h0, 32'h11};
        tick();
        check_val("bp_rdy_1word", recv_rdy[0], 1'b1);
        recv_msg = {32'h0, 32'h22};
        tick();
        recv_val = 2'b00;
        check_val("bp_rdy_full", recv_rdy[0], 1'b0);
        repeat (5) tick();
        check_val("bp_rdy_hold", recv_rdy[0],    1'b0);
        check_val("bp_val_hold", send_val,       2'b01);
        check_val("bp_head",     send_msg[31:0], 32'h11);
        send_rdy = 2'b01;
        tick();
        check_val("bp_second",     send_msg[31:0], 32'h22);
        check_val("bp_second_val", send_val,       2'b01);
        tick();
        check_val("bp_empty", send_val, 2'b00);

        // Reconfigure to multicast from input 0, empty FIFOs: 2-cycle cost
        control     = CFG_MC0;
        control_val = 1'b1;
        tick();
        check_val("mc_cfg_drain",   draining_o,  1'b1);
        check_val("mc_cfg_crdy",    control_rdy, 1'b1);
        check_val("mc_cfg_recvrdy", recv_rdy,    2'b00);
        tick();
        control_val = 1'b0;
        check_val("mc_cfg_loaded",  cfg_o,      CFG_MC0);
        check_val("mc_cfg_active",  draining_o, 1'b0);
        check_val("mc_cfg_recvrdy2", recv_rdy,  2'b01);

        // Multicast 0..3 with output 1 held off for the first 5 cycles
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            send_rdy = {(c >= 5), 1'b1};
            recv_val = (idx < 4) ? 2'b01 : 2'b00;
            recv_msg = {32'h0, 32'(idx)};
            if (c == 3) begin
                check_val("mc_stall_rdy",  recv_rdy[0], 1'b0);
                check_val("mc_stall_val",  send_val,    2'b10);
            end
            if (send_val[0] && send_rdy[0]) q0.push_back(send_msg[31:0]);
            if (send_val[1] && send_rdy[1]) q1.push_back(send_msg[63:32]);
            accepted = recv_val[0] && recv_rdy[0];
            tick();
            if (accepted) idx++;
        end
        recv_val = 2'b00;
        check_val("mc_q0_len", q0.size(), 4);
        check_val("mc_q1_len", q1.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("mc_q0_%0d", k), (k < q0.size()) ? q0[k] : 32'hDEAD, k);
            check_val($sformatf("mc_q1_%0d", k), (k < q1.size()) ? q1[k] : 32'hDEAD, k);
        end

        // Drain-reconfigure with two queued words
        send_rdy = 2'b00;
        recv_val = 2'b01;
        recv_msg = {32'h0, 32'h31};
        tick();
        recv_msg = {32'h0, 32'h32};
        tick();
        recv_val    = 2'b00;
        control     = CFG_SWAP;
        control_val = 1'b1;
        tick();
        check_val("dr_draining", draining_o,  1'b1);
        check_val("dr_crdy0",    control_rdy, 1'b0);
        check_val("dr_recvrdy",  recv_rdy,    2'b00);
        tick();
        tick();
        check_val("dr_crdy_hold", control_rdy, 1'b0);
        check_val("dr_head",      send_msg[31:0], 32'h31);
        send_rdy = 2'b11;
        tick();
        check_val("dr_crdy_1left", control_rdy, 1'b0);
        check_val("dr_cfg_old",    cfg_o,       CFG_MC0);
        tick();
        check_val("dr_crdy_empty", control_rdy, 1'b1);
        tick();
        control_val = 1'b0;
        check_val("dr_cfg_new",  cfg_o,      CFG_SWAP);
        check_val("dr_active",   draining_o, 1'b0);
        recv_val = 2'b10;
        recv_msg = {32'h77, 32'h0};
        check_val("dr_recvrdy_new", recv_rdy, 2'b11);
        tick();
        recv_val = 2'b00;
        check_val("dr_route_val", send_val,       2'b01);
        check_val("dr_route_msg", send_msg[31:0], 32'h77);
        tick();
        check_val("dr_route_empty", send_val, 2'b00);

        // Abort: one-cycle control_val while a word is queued
        send_rdy = 2'b00;
        recv_val = 2'b10;
        recv_msg = {32'h99, 32'h0};
        tick();
        recv_val    = 2'b00;
        control     = 4'h0;
        control_val = 1'b1;
        tick();
        control_val = 1'b0;
        check_val("ab_draining", draining_o,  1'b1);
        check_val("ab_crdy",     control_rdy, 1'b0);
        tick();
        check_val("ab_active",  draining_o, 1'b0);
        check_val("ab_cfg",     cfg_o,      CFG_SWAP);
        check_val("ab_recvrdy", recv_rdy,   2'b11);
        send_rdy = 2'b01;
        check_val("ab_head", send_msg[31:0], 32'h99);
        tick();
        check_val("ab_popped", send_val, 2'b00);
        send_rdy = 2'b11;
        recv_val = 2'b01;
        recv_msg = {32'h0, 32'h55};
        tick();
        recv_val = 2'b00;
        check_val("ab_resume_val", send_val,        2'b10);
        check_val("ab_resume_msg", send_msg[63:32], 32'h55);
        tick();

        // Mid-stream reset discards queued words
        send_rdy = 2'b00;
        recv_val = 2'b11;
        recv_msg = {32'hA1, 32'hB1};
        tick();
        recv_val = 2'b10;
        recv_msg = {32'hA2, 32'h0};
        tick();
        recv_val = 2'b00;
        check_val("mr_queued", send_val, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mr_send_val", send_val,   2'b00);
        check_val("mr_send_msg", send_msg,   64'h0);
        check_val("mr_cfg",      cfg_o,      CFG_DEF);
        check_val("mr_recvrdy",  recv_rdy,   2'b11);
        check_val("mr_draining", draining_o, 1'b0);
        send_rdy = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val($sformatf("mr_no_old_%0d", c), send_val, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
